// File: rtl/system_datapath_mem_if.sv
// system_datapath_mem_if: control strobes, I/O ports and memory signals of the datapath
// master: control unit / bench side (drives strobes, reads status and data)
// slave : datapath side (receives strobes, drives outport, CON, memory data and status)
interface system_datapath_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] inport_data;
  logic                  inport_data_ready;
  logic [DATA_WIDTH-1:0] outport_data;
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic [4:0]            opcode;
  logic                  IncPC;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic                  con_ff_bit;
  logic Mem_Read, Mem_Write, Mem_enable512x32;
  logic [DATA_WIDTH-1:0] Mem_to_datapath_out;
  logic [DATA_WIDTH-1:0] Mem_data_to_chip_out;
  logic [ADDR_WIDTH-1:0] MAR_address_out;
  logic                  memory_done;
  logic                  mem_overide;
  logic [ADDR_WIDTH-1:0] overide_address;
  logic [DATA_WIDTH-1:0] overide_data_in;
  modport master (
    output inport_data, inport_data_ready,
    output HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
    output opcode, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
    output Mem_Read, Mem_Write, Mem_enable512x32,
    output mem_overide, overide_address, overide_data_in,
    input  outport_data, con_ff_bit, Mem_to_datapath_out, Mem_data_to_chip_out,
    input  MAR_address_out, memory_done
  );
  modport slave (
    input  inport_data, inport_data_ready,
    input  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
    input  opcode, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
    input  Mem_Read, Mem_Write, Mem_enable512x32,
    input  mem_overide, overide_address, overide_data_in,
    output outport_data, con_ff_bit, Mem_to_datapath_out, Mem_data_to_chip_out,
    output MAR_address_out, memory_done
  );
endinterface

// File: rtl/system_datapath_mem.sv
// system_datapath_mem: single-bus 32-bit CPU datapath with a 512x32 word memory
// Clock: rising-edge clock; clear: asynchronous active-low reset
// io (slave): bus source selects, register load enables, ALU opcode/IncPC,
//   register-file select (Gra/Grb/Grc/Rin/Rout/BAout), I/O ports, memory controls,
//   memory override preload port, and status/data outputs
module system_datapath_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input logic Clock,
  input logic clear,
  system_datapath_mem_if.slave io
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0] r [16];
  logic [W-1:0] pc, ir, mdr, y, hi, lo, inport, outport;
  logic [W-1:0] bus, reg_q, c_sext, q, rem, mem_rd;
  logic [ADDR_WIDTH-1:0] mar;
  logic [2*W-1:0] z, z_n, dbl_r, dbl_l;
  logic con, con_n, done;
  logic [3:0] idx;
  logic [4:0] sh;
  logic [W-1:0] ram [2**ADDR_WIDTH];
  logic unused_ir_op;
  assign unused_ir_op = ^ir[31:27];
  assign idx = io.Gra ? ir[26:23] : io.Grb ? ir[22:19] : io.Grc ? ir[18:15] : 4'd0;
  // BAout treats R0 as a constant zero base address
  assign reg_q = (io.BAout && idx == 4'd0) ? '0 : r[idx];
  assign c_sext = {{(W-19){ir[18]}}, ir[18:0]};
  assign bus = (io.Rout || io.BAout) ? reg_q :
               io.HIout      ? hi :
               io.LOout      ? lo :
               io.Zhi_out    ? z[2*W-1:W] :
               io.Zlo_out    ? z[W-1:0] :
               io.PCout      ? pc :
               io.MDRout     ? mdr :
               io.Inport_out ? inport :
               io.Cout       ? c_sext : '0;
  assign mem_rd = (io.Mem_enable512x32 && io.Mem_Read) ? ram[mar] : '0;
  // IR[20] picks sign test vs zero test; IR[19] inverts the zero test / selects the sign value
  assign con_n = ir[20] ? (bus[W-1] == ir[19]) : ((bus == '0) != ir[19]);
  always_comb begin
    sh = bus[4:0];
    dbl_r = {y, y} >> sh;
    dbl_l = {y, y} << sh;
    q = '0;
    rem = '0;
    // y / -1 is handled apart so the most-negative dividend wraps instead of trapping
    if (bus == '1) q = '0 - y;
    else if (bus != '0) begin
      q = W'($signed(y) / $signed(bus));
      rem = W'($signed(y) % $signed(bus));
    end
    z_n = '0;
    if (io.IncPC) z_n[W-1:0] = bus + W'(1);
    else begin
      case (io.opcode)
        5'b00011: z_n[W-1:0] = y + bus;
        5'b00100: z_n[W-1:0] = y - bus;
        5'b00101: z_n[W-1:0] = y & bus;
        5'b00110: z_n[W-1:0] = y | bus;
        5'b00111: z_n[W-1:0] = y >> sh;
        5'b01000: z_n[W-1:0] = $signed(y) >>> sh;
        5'b01001: z_n[W-1:0] = y << sh;
        5'b01010: z_n[W-1:0] = dbl_r[W-1:0];
        5'b01011: z_n[W-1:0] = dbl_l[2*W-1:W];
        5'b01111: z_n = {{W{y[W-1]}}, y} * {{W{bus[W-1]}}, bus};
        5'b10000: z_n = {rem, q};
        5'b10001: z_n[W-1:0] = '0 - bus;
        5'b10010: z_n[W-1:0] = ~bus;
        default:  z_n[W-1:0] = bus;
      endcase
    end
  end
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc <= '0;
      ir <= '0;
      mar <= '0;
      mdr <= '0;
      y <= '0;
      z <= '0;
      hi <= '0;
      lo <= '0;
      con <= 1'b0;
      inport <= '0;
      outport <= '0;
      done <= 1'b0;
    end else begin
      if (io.Rin) r[idx] <= bus;
      if (io.PCin) pc <= bus;
      if (io.IRin) ir <= bus;
      if (io.MARin) mar <= bus[ADDR_WIDTH-1:0];
      if (io.MDRin) mdr <= io.Mem_Read ? mem_rd : bus;
      if (io.Yin) y <= bus;
      if (io.Zin) z <= z_n;
      if (io.HIin) hi <= bus;
      if (io.LOin) lo <= bus;
      if (io.CONin) con <= con_n;
      if (io.inport_data_ready) inport <= io.inport_data;
      if (io.outport_in) outport <= bus;
      done <= io.Mem_enable512x32;
    end
  end
  // memory contents survive reset, so the array sits in its own unreset process
  always_ff @(posedge Clock) begin
    if (io.Mem_enable512x32) begin
      if (io.mem_overide) ram[io.overide_address] <= io.overide_data_in;
      else if (io.Mem_Write) ram[mar] <= mdr;
    end
  end
  assign io.outport_data = outport;
  assign io.con_ff_bit = con;
  assign io.Mem_to_datapath_out = mem_rd;
  assign io.Mem_data_to_chip_out = mdr;
  assign io.MAR_address_out = mar;
  assign io.memory_done = done;
endmodule

// File: tb/tb_system_datapath_mem.sv
// tb_system_datapath_mem: directed and randomized checks of the datapath against a behavioural model
module tb_system_datapath_mem;
  logic Clock = 1'b0;
  logic clear = 1'b0;
  int vecs = 0;
  int errs = 0;
  system_datapath_mem_if s ();
  system_datapath_mem dut (.Clock(Clock), .clear(clear), .io(s));
  always #5 Clock = ~Clock;
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mdr, m_y, m_hi, m_lo, m_in, m_out;
  logic [31:0] m_ram [512];
  logic [8:0] m_mar;
  logic [63:0] m_z;
  logic m_con, m_done;
  logic [4:0] ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                           5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd31};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    s.inport_data = '0; s.inport_data_ready = 0;
    {s.HIout, s.LOout, s.Zhi_out, s.Zlo_out, s.PCout, s.MDRout, s.Inport_out, s.Cout} = '0;
    {s.MARin, s.Zin, s.PCin, s.MDRin, s.IRin, s.Yin, s.HIin, s.LOin, s.CONin, s.outport_in} = '0;
    s.opcode = '0; s.IncPC = 0;
    {s.Gra, s.Grb, s.Grc, s.Rin, s.Rout, s.BAout} = '0;
    {s.Mem_Read, s.Mem_Write, s.Mem_enable512x32, s.mem_overide} = '0;
    s.overide_address = '0; s.overide_data_in = '0;
  endtask
  task automatic model_reset();
    foreach (m_r[i]) m_r[i] = '0;
    {m_pc, m_ir, m_mdr, m_y, m_hi, m_lo, m_in, m_out} = '0;
    m_mar = '0; m_z = '0; m_con = 0; m_done = 0;
  endtask
  function automatic logic [31:0] bus_model(input logic [3:0] ix);
    if (s.Rout || s.BAout) return (s.BAout && ix == 4'd0) ? 32'd0 : m_r[ix];
    if (s.HIout) return m_hi;
    if (s.LOout) return m_lo;
    if (s.Zhi_out) return m_z[63:32];
    if (s.Zlo_out) return m_z[31:0];
    if (s.PCout) return m_pc;
    if (s.MDRout) return m_mdr;
    if (s.Inport_out) return m_in;
    if (s.Cout) return 32'($signed({m_ir[18:0], 13'd0}) >>> 13);
    return 32'd0;
  endfunction
  function automatic logic [63:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] op, input logic inc);
    int sa, sb, n;
    logic [31:0] t;
    sa = a; sb = b; n = int'(b[4:0]); t = a;
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      5'd3: return {32'd0, a + b};
      5'd4: return {32'd0, a - b};
      5'd5: return {32'd0, a & b};
      5'd6: return {32'd0, a | b};
      5'd7: return {32'd0, a >> n};
      5'd8: return {32'd0, 32'(sa >>> n)};
      5'd9: return {32'd0, a << n};
      5'd10: begin repeat (n) t = {t[0], t[31:1]}; return {32'd0, t}; end
      5'd11: begin repeat (n) t = {t[30:0], t[31]}; return {32'd0, t}; end
      5'd15: return 64'(longint'(sa) * longint'(sb));
      5'd16: begin
        if (sb == 0) return 64'd0;
        if (sb == -1) return {32'd0, 32'd0 - a};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      5'd17: return {32'd0, 32'd0 - b};
      5'd18: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction
  // one clock with the strobes already driven: predict, clock, compare, drop strobes
  task automatic cycle(input string tag);
    logic [3:0] ix;
    logic [31:0] b, rd;
    logic [63:0] zn;
    logic cn;
    #1;
    ix = s.Gra ? m_ir[26:23] : s.Grb ? m_ir[22:19] : s.Grc ? m_ir[18:15] : 4'd0;
    b = bus_model(ix);
    rd = (s.Mem_enable512x32 && s.Mem_Read) ? m_ram[m_mar] : 32'd0;
    chk({tag, "_rd"}, 64'(s.Mem_to_datapath_out), 64'(rd));
    case (m_ir[20:19])
      2'b00: cn = (b == 0);
      2'b01: cn = (b != 0);
      2'b10: cn = !b[31];
      default: cn = b[31];
    endcase
    zn = alu(m_y, b, s.opcode, s.IncPC);
    if (s.Mem_enable512x32) begin
      if (s.mem_overide) m_ram[s.overide_address] = s.overide_data_in;
      else if (s.Mem_Write) m_ram[m_mar] = m_mdr;
    end
    m_done = s.Mem_enable512x32;
    if (s.CONin) m_con = cn;
    if (s.Zin) m_z = zn;
    if (s.Rin) m_r[ix] = b;
    if (s.PCin) m_pc = b;
    if (s.IRin) m_ir = b;
    if (s.MARin) m_mar = b[8:0];
    if (s.MDRin) m_mdr = s.Mem_Read ? rd : b;
    if (s.Yin) m_y = b;
    if (s.HIin) m_hi = b;
    if (s.LOin) m_lo = b;
    if (s.inport_data_ready) m_in = s.inport_data;
    if (s.outport_in) m_out = b;
    @(posedge Clock);
    #1;
    chk({tag, "_out"}, 64'(s.outport_data), 64'(m_out));
    chk({tag, "_con"}, 64'(s.con_ff_bit), 64'(m_con));
    chk({tag, "_mar"}, 64'(s.MAR_address_out), 64'(m_mar));
    chk({tag, "_mdr"}, 64'(s.Mem_data_to_chip_out), 64'(m_mdr));
    chk({tag, "_done"}, 64'(s.memory_done), 64'(m_done));
    idle();
  endtask
  task automatic put(input logic [31:0] v);
    s.inport_data = v; s.inport_data_ready = 1; cycle("put");
  endtask
  task automatic alu_run(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic inc);
    put(a); s.Inport_out = 1; s.Yin = 1; cycle("ya");
    put(b); s.Inport_out = 1; s.Zin = 1; s.opcode = op; s.IncPC = inc; cycle("alu");
    s.Zlo_out = 1; s.outport_in = 1; cycle("zlo");
    s.Zhi_out = 1; s.outport_in = 1; cycle("zhi");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a, b;
    logic [4:0] op;
    foreach (m_ram[i]) m_ram[i] = '0;
    idle();
    model_reset();
    #12;
    chk("rst_con", 64'(s.con_ff_bit), 64'd0);
    chk("rst_out", 64'(s.outport_data), 64'd0);
    chk("rst_mar", 64'(s.MAR_address_out), 64'd0);
    chk("rst_done", 64'(s.memory_done), 64'd0);
    chk("rst_mdr", 64'(s.Mem_data_to_chip_out), 64'd0);
    clear = 1;
    put(32'h55);
    s.Inport_out = 1; s.PCin = 1; cycle("ld_pc");
    s.PCout = 1; s.outport_in = 1; cycle("pc_out");
    chk("pc_loaded", 64'(s.outport_data), 64'h55);
    #2 clear = 0;
    #1;
    chk("async_out", 64'(s.outport_data), 64'd0);
    chk("async_con", 64'(s.con_ff_bit), 64'd0);
    model_reset();
    clear = 1;
    s.PCout = 1; s.outport_in = 1; cycle("pc_clr");
    chk("pc_cleared", 64'(s.outport_data), 64'd0);
    s.mem_overide = 1; s.Mem_enable512x32 = 1; s.overide_address = 9'd0;
    s.overide_data_in = 32'h18900001; cycle("ovr");
    s.Mem_Read = 1; s.Mem_enable512x32 = 1;
    #1;
    chk("ovr_rd", 64'(s.Mem_to_datapath_out), 64'h18900001);
    chk("ovr_done", 64'(s.memory_done), 64'd1);
    cycle("ovr_read");
    s.PCout = 1; s.IncPC = 1; s.MARin = 1; s.Zin = 1; cycle("t0");
    chk("t0_mar", 64'(s.MAR_address_out), 64'd0);
    s.Zlo_out = 1; s.PCin = 1; s.MDRin = 1; s.Mem_Read = 1; s.Mem_enable512x32 = 1; cycle("t1");
    chk("t1_mdr", 64'(s.Mem_data_to_chip_out), 64'h18900001);
    s.MDRout = 1; s.IRin = 1; cycle("t2");
    s.PCout = 1; s.outport_in = 1; cycle("pc1");
    chk("pc_inc", 64'(s.outport_data), 64'd1);
    put(32'h14);
    s.Inport_out = 1; s.Grb = 1; s.Rin = 1; cycle("r2");
    s.Grb = 1; s.Rout = 1; s.Yin = 1; cycle("y");
    s.Cout = 1; s.Zin = 1; s.opcode = 5'b00011; cycle("add");
    s.Zlo_out = 1; s.Gra = 1; s.Rin = 1; cycle("r1");
    s.Gra = 1; s.Rout = 1; s.outport_in = 1; cycle("r1_out");
    chk("add_out", 64'(s.outport_data), 64'h15);
    put(32'h0007FFFF); s.Inport_out = 1; s.IRin = 1; cycle("ir_c");
    s.Cout = 1; s.outport_in = 1; cycle("c_out");
    chk("sext", 64'(s.outport_data), 64'hFFFFFFFF);
    put(32'h00880000); s.Inport_out = 1; s.IRin = 1; cycle("ir_ne");
    s.CONin = 1; cycle("con_zero_bus");
    chk("con_ne_0", 64'(s.con_ff_bit), 64'd0);
    s.Gra = 1; s.Rout = 1; s.CONin = 1; cycle("con_r1");
    chk("con_ne_r1", 64'(s.con_ff_bit), 64'd1);
    put(32'h99); s.Inport_out = 1; s.Rin = 1; cycle("r0");
    put(32'h0); s.Inport_out = 1; s.IRin = 1; cycle("ir_eq");
    s.CONin = 1; s.Inport_out = 1; cycle("con_clr");
    s.Gra = 1; s.BAout = 1; s.CONin = 1; cycle("con_ba");
    chk("con_ba_r0", 64'(s.con_ff_bit), 64'd1);
    s.Gra = 1; s.Rout = 1; s.outport_in = 1; cycle("r0_out");
    chk("r0_value", 64'(s.outport_data), 64'h99);
    put(32'd500); s.Inport_out = 1; s.MARin = 1; cycle("st_mar");
    chk("st_mar_500", 64'(s.MAR_address_out), 64'd500);
    put(32'h14); s.Inport_out = 1; s.MDRin = 1; cycle("st_mdr");
    s.Mem_Write = 1; s.Mem_enable512x32 = 1; cycle("st_wr");
    chk("st_mdr_kept", 64'(s.Mem_data_to_chip_out), 64'h14);
    s.Mem_Read = 1; s.Mem_enable512x32 = 1;
    #1;
    chk("st_read", 64'(s.Mem_to_datapath_out), 64'h14);
    cycle("st_rd");
    put(32'hABCD); s.Inport_out = 1; s.MDRin = 1; cycle("rw_mdr");
    s.Mem_Read = 1; s.Mem_Write = 1; s.Mem_enable512x32 = 1;
    #1;
    chk("rw_old_word", 64'(s.Mem_to_datapath_out), 64'h14);
    cycle("rw");
    s.Mem_Read = 1; s.Mem_enable512x32 = 1;
    #1;
    chk("rw_new_word", 64'(s.Mem_to_datapath_out), 64'hABCD);
    cycle("rw_rd");
    alu_run(32'd7, 32'd0, 5'd16, 1'b0);
    chk("div0_hi", 64'(s.outport_data), 64'd0);
    alu_run(32'hFFFFFFFD, 32'd5, 5'd15, 1'b0);
    chk("mul_neg_hi", 64'(s.outport_data), 64'hFFFFFFFF);
    alu_run(32'd17, 32'hFFFFFFF9, 5'd16, 1'b0);
    chk("div_rem_hi", 64'(s.outport_data), 64'd3);
    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      b = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
      op = ops[$urandom_range(14)];
      alu_run(a, b, op, $urandom_range(7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
